sme_driver: RTL and testbench

Transmit-side sequencer for the string-matching engine. A host preloads a string (up to 32 chars) and a pattern (up to 8 chars) into local buffers and pulses `start`. The block then serializes both onto the engine's `chardata`/`isstring`/`ispattern` bus, waits for the engine's `valid`, and captures `match`/`match_index` as a one-shot result with a timeout guard. It sits between the host/test harness and the matching engine.

---
 rtl/sme_driver.sv | 134 +++++++++++++
 tb/tb_sme_driver.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sme_driver.sv
// sme_driver: serializes a buffered string and pattern to the matching engine and captures its result with a timeout guard
module sme_driver #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld_str,
  input  logic       ld_pat,
  input  logic [4:0] ld_addr,
  input  logic [7:0] ld_data,
  input  logic [5:0] str_len,
  input  logic [3:0] pat_len,
  input  logic       reuse_str,
  input  logic       start,
  output logic       busy,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       valid,
  input  logic       match,
  input  logic [4:0] match_index,
  output logic       done,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       timeout
);
  typedef enum logic [2:0] {IDLE, SEND_STR, SEND_PAT, WAIT, REPORT} state_t;
  state_t state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [5:0] slen_q, slen_d;
  logic [3:0] plen_q, plen_d;
  logic [9:0] cnt_q, cnt_d;
  logic res_match_q, res_match_d, timeout_q, timeout_d;
  logic [4:0] res_index_q, res_index_d;
  logic [7:0] chardata_q, chardata_d;
  logic isstring_q, ispattern_q, busy_q, done_q;
  logic [7:0] str_q [STR_MAX];
  logic [7:0] pat_q [PAT_MAX];
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    slen_d = slen_q;
    plen_d = plen_q;
    cnt_d = cnt_q;
    res_match_d = res_match_q;
    res_index_d = res_index_q;
    timeout_d = timeout_q;
    unique case (state_q)
      IDLE: if (start && pat_len != 4'd0) begin
        slen_d = str_len > 6'(STR_MAX) ? 6'(STR_MAX) : str_len;
        plen_d = pat_len > 4'(PAT_MAX) ? 4'(PAT_MAX) : pat_len;
        idx_d = '0;
        res_match_d = 1'b0;
        res_index_d = '0;
        timeout_d = 1'b0;
        state_d = (reuse_str || str_len == 6'd0) ? SEND_PAT : SEND_STR;
      end
      SEND_STR: if ({1'b0, idx_q} == slen_q - 6'd1) begin
        idx_d = '0;
        state_d = SEND_PAT;
      end else idx_d = idx_q + 5'd1;
      SEND_PAT: if ({1'b0, idx_q} == {2'b0, plen_q} - 6'd1) begin
        cnt_d = '0;
        state_d = WAIT;
      end else idx_d = idx_q + 5'd1;
      WAIT: if (valid) begin
        res_match_d = match;
        res_index_d = match_index;
        timeout_d = 1'b0;
        state_d = REPORT;
      end else if (cnt_q == 10'(TIMEOUT - 1)) begin
        res_match_d = 1'b0;
        res_index_d = '0;
        timeout_d = 1'b1;
        state_d = REPORT;
      end else cnt_d = cnt_q + 10'd1;
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // outputs are decoded from next state so every port comes straight from a flop
  assign chardata_d = state_d == SEND_STR ? str_q[idx_d] :
                      state_d == SEND_PAT ? pat_q[idx_d[2:0]] : 8'h00;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      slen_q <= '0;
      plen_q <= '0;
      cnt_q <= '0;
      res_match_q <= 1'b0;
      res_index_q <= '0;
      timeout_q <= 1'b0;
      chardata_q <= '0;
      isstring_q <= 1'b0;
      ispattern_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      slen_q <= slen_d;
      plen_q <= plen_d;
      cnt_q <= cnt_d;
      res_match_q <= res_match_d;
      res_index_q <= res_index_d;
      timeout_q <= timeout_d;
      chardata_q <= chardata_d;
      isstring_q <= state_d == SEND_STR;
      ispattern_q <= state_d == SEND_PAT;
      busy_q <= state_d != IDLE;
      done_q <= state_d == REPORT;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STR_MAX; i++) str_q[i] <= '0;
      for (int i = 0; i < PAT_MAX; i++) pat_q[i] <= '0;
    end else if (state_q == IDLE) begin
      if (ld_str) str_q[ld_addr] <= ld_data;
      if (ld_pat) pat_q[ld_addr[2:0]] <= ld_data;
    end
  end
  assign busy = busy_q;
  assign chardata = chardata_q;
  assign isstring = isstring_q;
  assign ispattern = ispattern_q;
  assign done = done_q;
  assign res_match = res_match_q;
  assign res_index = res_index_q;
  assign timeout = timeout_q;
endmodule

// File: tb/tb_sme_driver.sv
// tb_sme_driver: directed and random transactions checked cycle by cycle against a timeline model of the transfer
module tb_sme_driver;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic reset, ld_str, ld_pat, reuse_str, start, valid, match;
  logic [4:0] ld_addr, match_index, res_index;
  logic [7:0] ld_data, chardata;
  logic [5:0] str_len;
  logic [3:0] pat_len;
  logic busy, isstring, ispattern, done, res_match, timeout;
  logic [7:0] mstr [32];
  logic [7:0] mpat [8];
  logic [7:0] eng_str [32];
  int eng_len = 0;
  int total = 0, bad = 0;
  sme_driver #(.STR_MAX(32), .PAT_MAX(8), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ld_str(ld_str), .ld_pat(ld_pat), .ld_addr(ld_addr),
    .ld_data(ld_data), .str_len(str_len), .pat_len(pat_len), .reuse_str(reuse_str),
    .start(start), .busy(busy), .chardata(chardata), .isstring(isstring),
    .ispattern(ispattern), .valid(valid), .match(match), .match_index(match_index),
    .done(done), .res_match(res_match), .res_index(res_index), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input bit s, input bit p, input logic [4:0] a, input logic [7:0] d);
    ld_str = s;
    ld_pat = p;
    ld_addr = a;
    ld_data = d;
    step();
    ld_str = 1'b0;
    ld_pat = 1'b0;
    if (s) mstr[a] = d;
    if (p) mpat[a[2:0]] = d;
  endtask
  task automatic load_text(input bit s, input string t);
    for (int i = 0; i < t.len(); i++) load(s, !s, 5'(i), t[i]);
  endtask
  function automatic int find(input int p);
    for (int s = 0; s + p <= eng_len; s++) begin
      bit ok = 1'b1;
      for (int j = 0; j < p; j++) if (eng_str[s + j] != mpat[j]) ok = 1'b0;
      if (ok) return s;
    end
    return -1;
  endfunction
  task automatic run_txn(input int sl, input int pl, input bit reuse, input int vdel,
                         input bit spur, input bit abuse, input bit rnd_res);
    int ls, p, w, vc, d, f;
    bit em, eto, e_is, e_ip;
    logic [4:0] ei;
    logic [7:0] ecd;
    p = pl > 8 ? 8 : pl;
    ls = (reuse || sl == 0) ? 0 : (sl > 32 ? 32 : sl);
    str_len = 6'(sl);
    pat_len = 4'(pl);
    reuse_str = reuse;
    start = 1'b1;
    if (p == 0) begin
      for (int c = 1; c <= 3; c++) begin
        step();
        start = 1'b0;
        chk("ignored_busy", busy, 0);
        chk("ignored_bus", {isstring, ispattern}, 0);
      end
      return;
    end
    if (ls > 0) begin
      for (int i = 0; i < 32; i++) eng_str[i] = mstr[i];
      eng_len = ls;
    end
    f = find(p);
    em = rnd_res ? 1'($urandom) : f >= 0;
    ei = rnd_res ? 5'($urandom) : (f >= 0 ? 5'(f) : 5'd0);
    w = ls + p + 1;
    vc = vdel >= 0 ? w + vdel : -100;
    if (vdel >= 0 && vdel < TO) begin
      d = vc + 1;
      eto = 1'b0;
    end else begin
      d = w + TO;
      em = 1'b0;
      ei = 5'd0;
      eto = 1'b1;
    end
    for (int c = 1; c <= d + 1; c++) begin
      step();
      start = abuse && c >= 2 && c <= 3;
      ld_str = abuse && c == 2;
      ld_addr = 5'd0;
      ld_data = 8'hff;
      valid = (c == vc) || (spur && c == ls + 1);
      match = c == vc ? em : 1'b1;
      match_index = c == vc ? ei : 5'h1f;
      e_is = c <= ls;
      e_ip = c > ls && c <= ls + p;
      ecd = e_is ? mstr[c - 1] : (e_ip ? mpat[c - ls - 1] : 8'h00);
      chk("isstring", isstring, e_is);
      chk("ispattern", ispattern, e_ip);
      chk("chardata", chardata, ecd);
      chk("busy", busy, c <= d);
      chk("done", done, c == d);
      chk("res_match", res_match, c >= d ? em : 1'b0);
      chk("res_index", res_index, c >= d ? ei : 5'd0);
      chk("timeout", timeout, c >= d ? eto : 1'b0);
    end
    start = 1'b0;
    ld_str = 1'b0;
    valid = 1'b0;
    match = 1'b0;
    match_index = '0;
  endtask
  initial begin
    reset = 1'b1;
    {ld_str, ld_pat, reuse_str, start, valid, match} = '0;
    ld_addr = '0;
    ld_data = '0;
    match_index = '0;
    str_len = '0;
    pat_len = '0;
    for (int i = 0; i < 32; i++) mstr[i] = 8'h00;
    for (int i = 0; i < 8; i++) mpat[i] = 8'h00;
    step();
    step();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_bus", {isstring, ispattern, chardata}, 0);
    chk("rst_done", done, 0);
    chk("rst_res", {res_match, res_index, timeout}, 0);
    load_text(1'b1, "abc def");
    load_text(1'b0, "def");
    run_txn(7, 3, 1'b0, 9, 1'b0, 1'b0, 1'b0);
    chk("t1_index", res_index, 4);
    load_text(1'b0, "^ab");
    run_txn(7, 3, 1'b1, 3, 1'b0, 1'b0, 1'b0);
    run_txn(7, 3, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    str_len = 6'd6;
    pat_len = 4'd2;
    reuse_str = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("pre_rst_byte", chardata, mstr[2]);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) mstr[i] = 8'h00;
    for (int i = 0; i < 8; i++) mpat[i] = 8'h00;
    chk("abort_isstring", isstring, 0);
    chk("abort_busy", busy, 0);
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_done", done, 0);
      step();
    end
    load_text(1'b1, "xyz");
    load_text(1'b0, "yz");
    run_txn(3, 2, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) load(1'b1, 1'b0, 5'(i), 8'($urandom));
    run_txn(40, 2, 1'b0, 2, 1'b0, 1'b0, 1'b1);
    run_txn(5, 12, 1'b0, 1, 1'b0, 1'b0, 1'b1);
    run_txn(5, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    run_txn(6, 2, 1'b0, 4, 1'b0, 1'b1, 1'b1);
    run_txn(6, 2, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    run_txn(4, 3, 1'b0, TO - 1, 1'b1, 1'b0, 1'b1);
    run_txn(4, 3, 1'b0, TO, 1'b0, 1'b0, 1'b1);
    load(1'b1, 1'b1, 5'd1, 8'h5a);
    run_txn(3, 2, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    run_txn(0, 4, 1'b0, 1, 1'b1, 1'b0, 1'b1);
    for (int n = 0; n < 10; n++) begin
      int nl;
      nl = $urandom_range(0, 10);
      for (int i = 0; i < nl; i++)
        load(1'($urandom), 1'($urandom), 5'($urandom), 8'($urandom));
      run_txn($urandom_range(0, 40), $urandom_range(0, 9), 1'($urandom),
              $urandom_range(0, 3) == 0 ? -1 : $urandom_range(0, TO + 2),
              1'($urandom), 1'($urandom), 1'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
